// File: rtl/mem_access_unit.sv
// Load/store unit with byte/halfword read-modify-write and sign/zero extension.
// Optional macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [31:0]       mem_readData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic              bad;
  } req_t;

  state_t      state, nxt;
  req_t        rq;
  logic        acc, bad_in;
  logic [31:0] wdata_q, ld_q;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return {{24{b[7] & ~f3[2]}}, b};
      2'b01:   return {{16{h[15] & ~f3[2]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (f3[1:0])
      2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Fault decode happens once, on the live request, and travels with it.
  always_comb begin
    bad_in = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: bad_in = 1'b0;
      3'b100, 3'b101:         bad_in = is_store;
      default:                bad_in = 1'b1;
    endcase
    if (is_load == is_store) bad_in = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (funct3[1:0] == 2'b01 && addr[0])          bad_in = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad_in = 1'b1;
`endif
  end

  assign acc = req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req_valid) begin
               if (bad_in)                     nxt = DONE;
               else if (is_load)               nxt = READ;
               else if (funct3 == 3'b010)      nxt = WRITE;
               else                            nxt = READ;
             end
      READ:  nxt = rq.is_load ? DONE : WRITE;
      WRITE: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE);
    mem_memRead  = (state == READ);
    mem_memWrite = (state == WRITE);
    done         = (state == DONE);
    err          = done && rq.bad;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  rq <= '0;
    else if (acc)  rq <= '{is_load: is_load, is_store: is_store, funct3: funct3,
                           addr: addr, bad: bad_in};

  // Sub-word stores reuse the write-data register to hold the merged word.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      wdata_q <= '0;
    else if (acc)
      wdata_q <= store_data;
    else if (state == READ && !rq.is_load)
      wdata_q <= merge(mem_readData, wdata_q, rq.funct3, rq.addr[1:0]);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                         ld_q <= '0;
    else if (state == READ && rq.is_load) ld_q <= load_ext(mem_readData, rq.funct3, rq.addr[1:0]);

  // Held load result is masked to zero while a store completes.
  assign load_data     = (done && !rq.is_load) ? 32'h0 : ld_q;
  assign mem_address   = {rq.addr[ADDR_W-1:2], 2'b00};
  assign mem_writeData = wdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the byte address on both the pipeline and memory sides.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid  in  1  MEM-stage request present.
REQ-005 SHALL have ports: req_ready  out  1  unit idle, request accepted this cycle if req_valid.
REQ-006 SHALL have ports: is_load, is_store  in  1 each  access type.
REQ-007 SHALL have ports: funct3  in  3  RV32 width/sign code.
REQ-008 SHALL have ports: addr  in  ADDR_W  byte address; store_data  in  32  store operand.
REQ-009 SHALL have ports: done  out  1  one-cycle completion pulse; load_data  out  32  extended load result; err  out  1  access fault, valid with done.
REQ-010 SHALL have ports: mem_address  out  ADDR_W  word-aligned address; mem_writeData  out  32; mem_memWrite  out  1; mem_memRead  out  1; mem_readData  in  32  combinational read data.

Function
REQ-011 SHALL implement FSM states IDLE, READ, WRITE, DONE; req_ready=1 only in IDLE.
REQ-012 SHALL accept on req_valid & req_ready, registering is_load, is_store, funct3, addr, and store_data.
REQ-013 SHALL handle loads as IDLE->READ->DONE, with mem_memRead=1 only in READ, mem_readData captured at the end of READ, and done at acceptance+2.
REQ-014 SHALL handle SW as IDLE->WRITE->DONE, with mem_memWrite=1 for exactly one cycle and done at acceptance+2.
REQ-015 SHALL handle SB/SH as read-modify-write IDLE->READ->WRITE->DONE, merging the byte/halfword lane into the captured word, with done at acceptance+3.
REQ-016 SHALL select lanes as: byte lane = addr[1:0]; halfword lane = addr[1].
REQ-017 SHALL decode funct3 as 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-018 SHALL treat as illegal: other funct3 values, stores with 100/101, and requests with both or neither of is_load/is_store; these go IDLE->DONE with err=1, done at acceptance+1, and no memory strobe.
REQ-019 SHALL drive mem_address={addr[ADDR_W-1:2],2'b00} from registered fields, and mem_writeData from a register; the strobes decode from the state register only.
REQ-020 SHALL hold load_data until the next load's DONE; load_data for a store SHALL be 0.
REQ-021 SHALL ignore req_valid while not in IDLE; DONE always returns to IDLE the next cycle.

Reset
REQ-022 SHALL, while reset_n=0, force state IDLE, mem_memRead=0, mem_memWrite=0, done=0, err=0, load_data=0, mem_address=0, mem_writeData=0, and req_ready=1.
REQ-023 SHALL abort an in-flight access on reset with no completion pulse; a write in progress SHALL have its strobe dropped immediately.

Configuration
REQ-024 SHALL, when MISALIGN_TRAP_EN is defined, treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as illegal per REQ-018.
REQ-025 SHALL, when MISALIGN_TRAP_EN is undefined, ignore the misaligned low bits (halfword uses addr[1], word ignores addr[1:0]) and never set err for alignment.

Verification
REQ-026 SHALL cover: memory word 0x100=0x876543A1, LB addr 0x100 -> load_data=0xFFFFFFA1, done at acceptance+2, one memRead cycle.
REQ-027 SHALL cover: same memory word, LHU addr 0x102 -> load_data=0x00008765, err=0.
REQ-028 SHALL cover: SB addr 0x101 data 0x000000CC -> one memRead then one memWrite of 0x8765CCA1 to 0x100, done at acceptance+3.
REQ-029 SHALL cover: SW addr 0x104 data 0xDEADBEEF -> a single memWrite cycle, done at acceptance+2; a req_valid held during busy is not accepted until IDLE.
REQ-030 SHALL cover: LW addr 0x102 -> with MISALIGN_TRAP_EN, err=1 and done at acceptance+1 with no strobes; without it, load_data=0x876543A1.
REQ-031 SHALL cover: reset_n pulled low during the WRITE state of an SB -> mem_memWrite=0 immediately, no done, and req_ready=1 after release.
